parallel_in_serial_out_piso_tx: RTL and testbench
=================================================

# parallel_in_serial_out_piso_tx

Parallel-in, serial-out shift-register transmitter: the serialising counterpart of the team's PIPO/SIPO register family. It accepts a DATA_WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock with a qualifying valid strobe plus frame-start and frame-done markers. Back-to-back words stream with no idle gap. It feeds serial links and SIPO receivers elsewhere in the design.

## Interface
- DATA_WIDTH, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 transmits bit DATA_WIDTH-1 first; 0 transmits bit 0 first.
- IDLE_LEVEL, 1'b0, value driven on Serial_Data_Out when no frame is active.

- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Load_Valid_In  input  1  a word is offered on Parallel_Data_In.
- Load_Ready_Out  output  1  the block can accept a word this cycle.
- Parallel_Data_In  input  DATA_WIDTH  word to transmit; sampled only on acceptance.
- Serial_Data_Out  output  1  current serial bit.
- Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit.
- Frame_Start_Out  output  1  high during the first bit of each frame.
- Frame_Done_Out  output  1  high during the last bit of each frame.
- Busy_Out  output  1  a frame is in progress (state SHIFT).

## Operation
- States:
  - IDLE: no frame.
  - SHIFT: transmitting; the bit counter Bit_Cnt counts 0..DATA_WIDTH-1 and is $clog2(DATA_WIDTH) bits wide.
- Load_Ready_Out is combinational:
  - high in IDLE;
  - high in SHIFT when Bit_Cnt == DATA_WIDTH-1;
  - low otherwise.
- Acceptance: Load_Valid_In && Load_Ready_Out at a falling edge.
  - Capture Parallel_Data_In into the shift register.
  - Set Bit_Cnt to 0 and enter SHIFT.
- In SHIFT, with no acceptance and Bit_Cnt < DATA_WIDTH-1:
  - shift by one position (left if MSB_FIRST, right otherwise);
  - increment Bit_Cnt.
- In SHIFT, with no acceptance and Bit_Cnt == DATA_WIDTH-1: return to IDLE.
- In SHIFT, with acceptance at Bit_Cnt == DATA_WIDTH-1: reload and stay in SHIFT, which gives a gapless next frame.
- Load_Valid_In while Load_Ready_Out is low is ignored. The word is not captured and the current frame is unaffected.
- Output decode:
  - Serial_Data_Out is the shift-register MSB if MSB_FIRST, else the LSB; in IDLE it is IDLE_LEVEL.
  - Serial_Valid_Out and Busy_Out are high in SHIFT.
  - Frame_Start_Out = SHIFT && Bit_Cnt == 0.
  - Frame_Done_Out = SHIFT && Bit_Cnt == DATA_WIDTH-1.
- Reset (asynchronous, any time, including mid-frame):
  - state goes to IDLE, Bit_Cnt and the shift register clear to 0;
  - the frame is aborted with no Frame_Done_Out pulse;
  - outputs: Serial_Data_Out = IDLE_LEVEL; Serial_Valid_Out, Frame_Start_Out, Frame_Done_Out and Busy_Out are 0; Load_Ready_Out is 1.
- Release of reset: the first acceptance can occur at the first falling edge after Reset_In deasserts.

## Timing
- Falling edge k accepts word W.
- Bit i of the frame (in transmit order) is presented from edge k+i to edge k+i+1, for i = 0..DATA_WIDTH-1.
- Latency from acceptance to first bit is 0 cycles: the bit is valid immediately after edge k.
- Frame_Start_Out is high for one cycle starting at edge k.
- Frame_Done_Out and Load_Ready_Out are high for one cycle starting at edge k+DATA_WIDTH-1.
- Edge k+DATA_WIDTH:
  - with a new acceptance, bit 0 of the next word follows with no gap;
  - otherwise, return to IDLE with Serial_Valid_Out low.
- Sustained throughput is 1 word per DATA_WIDTH cycles.
- Minimum IDLE dwell is 0 cycles.
- Reset assertion takes effect immediately, without waiting for a clock edge.

## Test plan
- **Reset values:** assert Reset_In with no clock -> Serial_Data_Out = 0, Serial_Valid_Out = 0, Busy_Out = 0, Frame_Start_Out = 0, Frame_Done_Out = 0, Load_Ready_Out = 1.
- **MSB-first frame:** MSB_FIRST = 1, accept 8'hB2 -> serial bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles.
  - Frame_Start_Out is high on bit 0 and Frame_Done_Out is high on bit 7.
  - Then IDLE with Serial_Data_Out = 0.
- **LSB-first frame:** MSB_FIRST = 0, accept 8'h1E -> serial bits 0,1,1,1,1,0,0,0.
- **Back-to-back frames:** hold Load_Valid_In high with 8'hFF, then present 8'h00 while Load_Ready_Out is high during bit 7.
  - Required: 16 consecutive valid cycles, eight 1s followed by eight 0s.
  - Busy_Out never drops between the frames.
  - Frame_Start_Out pulses at cycles 0 and 8.
- **Load while busy:** during bit 3 of an 8'hB2 frame, pulse Load_Valid_In with 8'h55 -> ignored; the remaining bits 1,0,0,1,0 are unchanged and no new frame starts.
- **Reset mid-frame:** assert Reset_In during bit 4 of a frame.
  - Required: immediate IDLE outputs and no Frame_Done_Out pulse.
  - After release, accept 8'hB2 -> a clean frame as in the MSB-first test.

Source files
------------

// File: rtl/parallel_in_serial_out_piso_tx.sv
// Parallel-in, serial-out transmitter: accepts a word over a valid/ready handshake and
// shifts it out one bit per falling clock edge with frame-start/done markers.
module parallel_in_serial_out_piso_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic                  Busy_Out
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;

  logic shifting;
  logic last_bit;
  logic accept;

  assign shifting = (state_q == StShift);
  assign last_bit = shifting && (bit_cnt_q == LastCnt);
  assign accept   = Load_Valid_In && Load_Ready_Out;

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Acceptance takes priority so a load on the last bit restarts with no idle gap.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      state_d   = StShift;
      shift_d   = Parallel_Data_In;
      bit_cnt_d = '0;
    end else if (shifting) begin
      if (last_bit) begin
        state_d = StIdle;
      end else begin
        if (MSB_FIRST) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    Load_Ready_Out   = !shifting || last_bit;
    Serial_Valid_Out = shifting;
    Busy_Out         = shifting;
    Frame_Start_Out  = shifting && (bit_cnt_q == '0);
    Frame_Done_Out   = last_bit;
    Serial_Data_Out  = IDLE_LEVEL;
    if (shifting) begin
      Serial_Data_Out = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    end
  end

endmodule

// File: tb/tb_parallel_in_serial_out_piso_tx.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus; expected bits are
// queued on each modelled acceptance and popped by a monitor on every valid serial cycle.
module tb_parallel_in_serial_out_piso_tx;

  localparam int W = 8;

  logic         Clk_In = 1'b1;
  logic         Reset_In = 1'b1;
  logic         Load_Valid_In = 1'b0;
  logic [W-1:0] Parallel_Data_In = '0;
  logic         clk_run = 1'b0;

  logic rdy_m, dat_m, vld_m, st_m, dn_m, bsy_m;
  logic rdy_l, dat_l, vld_l, st_l, dn_l, bsy_l;

  parallel_in_serial_out_piso_tx #(
    .DATA_WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_msb (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Load_Valid_In(Load_Valid_In),
    .Load_Ready_Out(rdy_m), .Parallel_Data_In(Parallel_Data_In),
    .Serial_Data_Out(dat_m), .Serial_Valid_Out(vld_m), .Frame_Start_Out(st_m),
    .Frame_Done_Out(dn_m), .Busy_Out(bsy_m)
  );

  parallel_in_serial_out_piso_tx #(
    .DATA_WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) u_lsb (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Load_Valid_In(Load_Valid_In),
    .Load_Ready_Out(rdy_l), .Parallel_Data_In(Parallel_Data_In),
    .Serial_Data_Out(dat_l), .Serial_Valid_Out(vld_l), .Frame_Start_Out(st_l),
    .Frame_Done_Out(dn_l), .Busy_Out(bsy_l)
  );

  initial forever begin
    #5;
    if (clk_run) Clk_In = ~Clk_In;
  end

  typedef struct packed {
    logic bm;
    logic bl;
    logic st;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   left = 0;  // bits of the current frame still to be presented, incl. the one on the line

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every valid serial cycle consumes one expected bit.
  initial forever begin
    @(posedge Clk_In);
    if (vld_m === 1'b1 || vld_l === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {30'd0, vld_m, vld_l}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("msb_valid", vld_m, 1'b1);
        chk("lsb_valid", vld_l, 1'b1);
        chk("msb_bit", dat_m, e.bm);
        chk("lsb_bit", dat_l, e.bl);
        chk("msb_start", st_m, e.st);
        chk("lsb_start", st_l, e.st);
        chk("msb_done", dn_m, e.dn);
        chk("lsb_done", dn_l, e.dn);
      end
    end
  end

  // One cycle: check control outputs against the model, then offer inputs for the next edge.
  task automatic step(input logic v, input logic [W-1:0] d);
    @(posedge Clk_In);
    chk("ready", rdy_m, left <= 1);
    chk("ready_lsb", rdy_l, left <= 1);
    chk("busy", bsy_m, left > 0);
    chk("busy_lsb", bsy_l, left > 0);
    if (left == 0) begin
      chk("idle_vld", vld_m, 1'b0);
      chk("idle_lvl_msb", dat_m, 1'b0);
      chk("idle_lvl_lsb", dat_l, 1'b1);
      chk("idle_done", {dn_m, dn_l}, 2'b00);
    end
    #2;
    Load_Valid_In    = v;
    Parallel_Data_In = d;
    if (v && left <= 1) begin
      for (int i = 0; i < W; i++) exp_q.push_back({d[W-1-i], d[i], i == 0, i == W - 1});
      left = W;
    end else if (left > 0) begin
      left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(255));
  endtask

  initial begin
    // Reset with no clock running.
    #3;
    chk("rst_dat_msb", dat_m, 1'b0);
    chk("rst_dat_lsb", dat_l, 1'b1);
    chk("rst_vld", {vld_m, vld_l}, 2'b00);
    chk("rst_busy", {bsy_m, bsy_l}, 2'b00);
    chk("rst_start", {st_m, st_l}, 2'b00);
    chk("rst_done", {dn_m, dn_l}, 2'b00);
    chk("rst_ready", {rdy_m, rdy_l}, 2'b11);
    clk_run = 1'b1;
    @(posedge Clk_In);
    #1 Reset_In = 1'b0;

    // MSB-first 8'hB2 / LSB-first view of the same word, then 8'h1E.
    step(1'b1, 8'hB2);
    idle(W + 1);
    step(1'b1, 8'h1E);
    idle(W + 1);

    // Back-to-back: hold valid with FF, switch to 00 when ready rises on bit 7.
    step(1'b1, 8'hFF);
    for (int i = 0; i < W - 1; i++) step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    idle(W + 1);

    // Load while busy is ignored.
    step(1'b1, 8'hB2);
    idle(2);
    step(1'b1, 8'h55);
    idle(W);

    // Reset mid-frame: bit 4 on the line, then asynchronous reset.
    step(1'b1, 8'hB2);
    idle(4);
    @(posedge Clk_In);
    #2 Reset_In = 1'b1;
    #1;
    chk("mid_rst_vld", {vld_m, vld_l}, 2'b00);
    chk("mid_rst_busy", {bsy_m, bsy_l}, 2'b00);
    chk("mid_rst_done", {dn_m, dn_l}, 2'b00);
    chk("mid_rst_start", {st_m, st_l}, 2'b00);
    chk("mid_rst_ready", {rdy_m, rdy_l}, 2'b11);
    chk("mid_rst_dat", {dat_m, dat_l}, 2'b01);
    exp_q.delete();
    left = 0;
    Load_Valid_In = 1'b0;
    @(negedge Clk_In);
    #1;
    chk("rst_hold_done", {dn_m, dn_l, vld_m}, 3'b000);
    @(posedge Clk_In);
    #1 Reset_In = 1'b0;
    step(1'b1, 8'hB2);
    idle(W + 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) step(($urandom_range(3) != 0), $urandom_range(255));
    idle(W + 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1);
  end

endmodule
